// File: rtl/sht40_pkg.sv
// Shared constants, index map, FSM encoding and fixed-point conversion helpers for the
// SHT40 measurement-frame decoder.
package sht40_pkg;

  localparam int unsigned FRAME_BYTES = 6;
  localparam logic [7:0]  CRC_INIT    = 8'hFF;
  localparam logic [7:0]  CRC_POLY    = 8'h31;

  localparam logic [2:0] IDX_T_MSB  = 3'd0;
  localparam logic [2:0] IDX_T_LSB  = 3'd1;
  localparam logic [2:0] IDX_T_CRC  = 3'd2;
  localparam logic [2:0] IDX_RH_MSB = 3'd3;
  localparam logic [2:0] IDX_RH_LSB = 3'd4;
  localparam logic [2:0] IDX_RH_CRC = 3'd5;

  localparam logic [0:0] ST_RECV    = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  localparam logic [31:0] CONV_T_SPAN  = 32'd17500;
  localparam logic [31:0] CONV_T_OFFS  = 32'd4500;
  localparam logic [31:0] CONV_RH_SPAN = 32'd12500;
  localparam logic [31:0] CONV_RH_OFFS = 32'd600;
  localparam logic [31:0] CONV_RH_MAX  = 32'd10000;

  // Temperature in 0.01 degC: -4500 + (17500 * raw) / 2^16.
  function automatic logic signed [15:0] conv_temp(input logic [15:0] raw);
    logic [31:0]        prod;
    logic signed [31:0] val;
    prod = CONV_T_SPAN * {16'd0, raw};
    val  = $signed({16'd0, prod[31:16]}) - $signed(CONV_T_OFFS);
    return val[15:0];
  endfunction

  // Relative humidity in 0.01 %RH, clamped to the physical 0..100 % range.
  function automatic logic [15:0] conv_rh(input logic [15:0] raw);
    logic [31:0]        prod;
    logic signed [31:0] val;
    prod = CONV_RH_SPAN * {16'd0, raw};
    val  = $signed({16'd0, prod[31:16]}) - $signed(CONV_RH_OFFS);
    if (val < 0) begin
      return 16'd0;
    end else if (val > $signed(CONV_RH_MAX)) begin
      return CONV_RH_MAX[15:0];
    end else begin
      return val[15:0];
    end
  endfunction

endpackage

// File: rtl/sht40_crc8_serial.sv
// Bit-serial Sensirion CRC-8 engine: one message bit per clock, MSB first.
// init reseeds and cancels any shift in progress; load is ignored while busy.
module sht40_crc8_serial
  import sht40_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       load,
  input  logic [7:0] data,
  input  logic [7:0] seed,
  output logic       busy,
  output logic [7:0] crc
);

  logic [3:0] r_cnt;
  logic [7:0] r_sr;
  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ r_sr[7];
  assign busy = (r_cnt != 4'd0);
  assign crc  = r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
      r_sr  <= 8'd0;
      r_crc <= CRC_INIT;
    end else if (init) begin
      r_cnt <= 4'd0;
      r_crc <= seed;
    end else if (load && !busy) begin
      r_cnt <= 4'd8;
      r_sr  <= data;
    end else if (busy) begin
      r_cnt <= r_cnt - 4'd1;
      r_sr  <= {r_sr[6:0], 1'b0};
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/sht40_frame_decoder.sv
// Decodes SHT40 six-byte measurement frames, checks both words by CRC-8 and publishes raw words.
// Define SHT40_CONVERT_EN to add registered temp_cdeg / rh_cpct engineering-unit outputs.
module sht40_frame_decoder
  import sht40_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               byte_strobe,
  input  logic [7:0]         byte_data,
  output logic [15:0]        temp_raw,
  output logic [15:0]        rh_raw,
  output logic               frame_valid,
  output logic               crc_error,
  output logic               overrun_error,
  output logic [2:0]         byte_index,
  output logic               busy
`ifdef SHT40_CONVERT_EN
  ,
  output logic signed [15:0] temp_cdeg,
  output logic [15:0]        rh_cpct
`endif
);

  logic [0:0]  r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_t_hold;
  logic [15:0] r_rh_hold;
  logic [15:0] r_temp;
  logic [15:0] r_rh;
  logic        r_valid;
  logic        r_crc_err;
  logic        r_ovr;

  logic        w_accept;
  logic        w_is_crc;
  logic        w_crc_match;
  logic        w_crc_busy;
  logic [7:0]  w_crc;
  logic        w_crc_init;
  logic        w_crc_load;
  logic        w_frame_ok;
  logic [15:0] w_rh_word;

  // frame_start overrides a coincident strobe; DISCARD swallows strobes silently.
  assign w_accept    = byte_strobe && !frame_start && (r_state == ST_RECV);
  assign w_is_crc    = (r_idx == IDX_T_CRC) || (r_idx == IDX_RH_CRC);
  assign w_crc_match = (byte_data == w_crc);
  assign w_crc_load  = w_accept && !w_crc_busy && !w_is_crc;
  assign w_crc_init  = frame_start || (w_accept && !w_crc_busy && w_is_crc && w_crc_match);
  assign w_frame_ok  = w_accept && !w_crc_busy && (r_idx == IDX_RH_CRC) && w_crc_match;
  assign w_rh_word   = r_rh_hold;

  sht40_crc8_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (w_crc_init),
    .load (w_crc_load),
    .data (byte_data),
    .seed (CRC_INIT),
    .busy (w_crc_busy),
    .crc  (w_crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RECV;
      r_idx     <= IDX_T_MSB;
      r_t_hold  <= 16'd0;
      r_rh_hold <= 16'd0;
      r_temp    <= 16'd0;
      r_rh      <= 16'd0;
      r_valid   <= 1'b0;
      r_crc_err <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_crc_err <= 1'b0;
      r_ovr     <= 1'b0;
      if (frame_start) begin
        r_state <= ST_RECV;
        r_idx   <= IDX_T_MSB;
      end else if (w_accept) begin
        if (w_crc_busy) begin
          r_ovr   <= 1'b1;
          r_state <= ST_DISCARD;
        end else if (w_is_crc) begin
          if (!w_crc_match) begin
            r_crc_err <= 1'b1;
            r_state   <= ST_DISCARD;
          end else if (r_idx == IDX_T_CRC) begin
            r_idx <= IDX_RH_MSB;
          end else begin
            r_temp  <= r_t_hold;
            r_rh    <= w_rh_word;
            r_valid <= 1'b1;
            r_idx   <= IDX_T_MSB;
          end
        end else begin
          case (r_idx)
            IDX_T_MSB:  r_t_hold[15:8]  <= byte_data;
            IDX_T_LSB:  r_t_hold[7:0]   <= byte_data;
            IDX_RH_MSB: r_rh_hold[15:8] <= byte_data;
            default:    r_rh_hold[7:0]  <= byte_data;
          endcase
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign temp_raw      = r_temp;
  assign rh_raw        = r_rh;
  assign frame_valid   = r_valid;
  assign crc_error     = r_crc_err;
  assign overrun_error = r_ovr;
  assign byte_index    = r_idx;
  assign busy          = w_crc_busy;

`ifdef SHT40_CONVERT_EN
  logic signed [15:0] r_temp_cdeg;
  logic [15:0]        r_rh_cpct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_temp_cdeg <= 16'sd0;
      r_rh_cpct   <= 16'd0;
    end else if (!frame_start && w_frame_ok) begin
      r_temp_cdeg <= conv_temp(r_t_hold);
      r_rh_cpct   <= conv_rh(w_rh_word);
    end
  end

  assign temp_cdeg = r_temp_cdeg;
  assign rh_cpct   = r_rh_cpct;
`endif

endmodule

// File: tb/tb_sht40_frame_decoder.sv
// Scoreboard bench for sht40_frame_decoder: directed frames plus randomized frames and spacing.
`timescale 1ns/1ps
module tb_sht40_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        byte_strobe = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic [15:0] temp_raw;
  logic [15:0] rh_raw;
  logic        frame_valid;
  logic        crc_error;
  logic        overrun_error;
  logic [2:0]  byte_index;
  logic        busy;
`ifdef SHT40_CONVERT_EN
  logic signed [15:0] temp_cdeg;
  logic [15:0]        rh_cpct;
`endif

  sht40_frame_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .byte_strobe   (byte_strobe),
    .byte_data     (byte_data),
    .temp_raw      (temp_raw),
    .rh_raw        (rh_raw),
    .frame_valid   (frame_valid),
    .crc_error     (crc_error),
    .overrun_error (overrun_error),
    .byte_index    (byte_index),
    .busy          (busy)
`ifdef SHT40_CONVERT_EN
    ,
    .temp_cdeg     (temp_cdeg),
    .rh_cpct       (rh_cpct)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: CRC as remainder of polynomial long division, seed folded into the first byte.
  function automatic logic [7:0] crc8_word(input logic [15:0] w);
    logic [23:0] rem;
    rem = {w ^ 16'hFF00, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (rem[i]) rem[i -: 9] = rem[i -: 9] ^ 9'h131;
    end
    return rem[7:0];
  endfunction

  typedef struct {
    logic [2:0]  kind;  // {frame_valid, crc_error, overrun_error}
    int          due;
    logic [15:0] t;
    logic [15:0] rh;
  } exp_t;

  exp_t q[$];

  // Transaction-level model state.
  bit          m_discard = 1'b0;
  int          m_idx = 0;
  logic [7:0]  m_buf[6];
  int          m_last_load = -100;
  logic [15:0] m_temp = 16'd0;
  logic [15:0] m_rh = 16'd0;

  task automatic push(input logic [2:0] kind, input int due);
    exp_t x;
    x.kind = kind;
    x.due  = due;
    x.t    = m_temp;
    x.rh   = m_rh;
    q.push_back(x);
  endtask

  task automatic model_reset();
    m_discard   = 1'b0;
    m_idx       = 0;
    m_last_load = -100;
    m_temp      = 16'd0;
    m_rh        = 16'd0;
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t       x;
    logic [2:0] act;
    if (!rst) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL event_missing: got none, expected kind %b at cycle %0d", q[0].kind, q[0].due);
        void'(q.pop_front());
      end
      act = {frame_valid, crc_error, overrun_error};
      if (act != 3'b000) begin
        if (q.size() == 0) begin
          check("event_unexpected", {29'd0, act}, 32'd0);
        end else begin
          x = q.pop_front();
          check("event_kind", {29'd0, act}, {29'd0, x.kind});
          check("event_cycle", cyc, x.due);
          if (x.kind == 3'b100) begin
            check("temp_raw_on_valid", {16'd0, temp_raw}, {16'd0, x.t});
            check("rh_raw_on_valid", {16'd0, rh_raw}, {16'd0, x.rh});
`ifdef SHT40_CONVERT_EN
            begin
              int tc;
              int rc;
              tc = -4500 + ((17500 * int'(x.t)) >>> 16);
              rc = -600 + ((12500 * int'(x.rh)) >>> 16);
              if (rc < 0) rc = 0;
              if (rc > 10000) rc = 10000;
              check("temp_cdeg", {{16{temp_cdeg[15]}}, temp_cdeg}, tc);
              check("rh_cpct", {16'd0, rh_cpct}, rc);
            end
`endif
          end
        end
      end
    end
  end

  // Issues one strobe and waits gap cycles; strobe edges end up gap+1 cycles apart.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_fs);
    int  e;
    int  bcnt;
    bit  loads;
    @(posedge clk);
    #1;
    byte_strobe = 1'b1;
    byte_data   = b;
    frame_start = with_fs;
    e     = cyc + 1;
    loads = 1'b0;
    if (with_fs) begin
      m_discard   = 1'b0;
      m_idx       = 0;
      m_last_load = -100;
    end else if (!m_discard) begin
      if (e - m_last_load <= 8) begin
        push(3'b001, e);
        m_discard = 1'b1;
      end else if (m_idx == 2 || m_idx == 5) begin
        if (crc8_word({m_buf[m_idx-2], m_buf[m_idx-1]}) != b) begin
          push(3'b010, e);
          m_discard = 1'b1;
        end else if (m_idx == 2) begin
          m_idx = 3;
        end else begin
          m_temp = {m_buf[0], m_buf[1]};
          m_rh   = {m_buf[3], m_buf[4]};
          push(3'b100, e);
          m_idx = 0;
        end
      end else begin
        m_buf[m_idx] = b;
        m_idx++;
        m_last_load = e;
        loads = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    byte_strobe = 1'b0;
    frame_start = 1'b0;
    bcnt = 0;
    for (int i = 0; i < gap; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bcnt++;
    end
    if (loads && gap >= 10) check("busy_cycles", bcnt, 8);
    check("byte_index", {29'd0, byte_index}, m_idx);
    check("temp_raw_hold", {16'd0, temp_raw}, {16'd0, m_temp});
    check("rh_raw_hold", {16'd0, rh_raw}, {16'd0, m_rh});
  endtask

  task automatic send_fs();
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    m_discard   = 1'b0;
    m_idx       = 0;
    m_last_load = -100;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    check("fs_byte_index", {29'd0, byte_index}, 32'd0);
    check("fs_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_temp_raw"}, {16'd0, temp_raw}, 32'd0);
    check({tag, "_rh_raw"}, {16'd0, rh_raw}, 32'd0);
    check({tag, "_pulses"}, {29'd0, frame_valid, crc_error, overrun_error}, 32'd0);
    check({tag, "_byte_index"}, {29'd0, byte_index}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0]  good[6];
  logic [7:0]  fr[6];
  logic [15:0] w0;
  logic [15:0] w1;

  task automatic send_frame(input int gap);
    for (int i = 0; i < 6; i++) send_byte(fr[i], gap, 1'b0);
  endtask

  initial begin
    good[0] = 8'hBE; good[1] = 8'hEF; good[2] = 8'h92;
    good[3] = 8'h00; good[4] = 8'h00; good[5] = 8'h81;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Known-good frame at relaxed spacing.
    fr = good;
    send_frame(39);

    // Corrupted T CRC, remaining bytes must be ignored.
    send_fs();
    fr = good;
    fr[2] = 8'h93;
    send_frame(39);
    send_fs();
    fr = good;
    send_frame(39);

    // Second data byte arrives while the engine is still shifting.
    send_fs();
    send_byte(8'hBE, 2, 1'b0);
    for (int i = 1; i < 6; i++) send_byte(good[i], 15, 1'b0);

    // frame_start coincident with the first byte: that byte is dropped.
    send_byte(8'hBE, 15, 1'b1);
    fr = good;
    send_frame(15);

    // Asynchronous reset mid-frame, while the engine is busy.
    send_fs();
    for (int i = 0; i < 3; i++) send_byte(good[i], 15, 1'b0);
    send_byte(good[3], 3, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    fr = good;
    send_frame(15);

    // Randomized frames, spacing and occasional corruption / overrun / coincident start.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 7) send_fs();
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      fr[0] = w0[15:8]; fr[1] = w0[7:0]; fr[2] = crc8_word(w0);
      fr[3] = w1[15:8]; fr[4] = w1[7:0]; fr[5] = crc8_word(w1);
      if ($urandom_range(0, 6) == 0) fr[2] = fr[2] ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 6) == 0) fr[5] = fr[5] ^ 8'(1 << $urandom_range(0, 7));
      for (int b = 0; b < 6; b++) begin
        send_byte(fr[b], ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : $urandom_range(9, 20),
                  ($urandom_range(0, 29) == 0));
      end
    end

    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sht40_frame_decoder.md
Name: sht40_frame_decoder

Overview:
Sits directly downstream of the I2C master's receive path. It consumes the six bytes of an SHT40 measurement read in order: T_MSB, T_LSB, T_CRC, RH_MSB, RH_LSB, RH_CRC. It checks each word with the Sensirion CRC-8 using a bit-serial engine. It publishes validated raw temperature and humidity words, and drives the crc_error pulse that feeds the master's CRC_Error_Out abort input.

Parameters:
FRAME_BYTES, 6, bytes per measurement frame (fixed; two words, each 2 data bytes + 1 CRC byte)
CRC_INIT, 8'hFF, CRC register seed at the start of each word
CRC_POLY, 8'h31, CRC polynomial (x^8+x^5+x^4+1), MSB-first, no reflection, no final XOR

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
frame_start  input  1  one-cycle pulse; clears byte index and CRC, starts a new frame (issued when the master enters receive)
byte_strobe  input  1  one-cycle pulse; byte_data is valid (integration derives it from a change of the master's byte count)
byte_data  input  8  received byte (master Data_Received)
temp_raw  output  16  last validated temperature word
rh_raw  output  16  last validated humidity word
frame_valid  output  1  one-cycle pulse; both words passed CRC, outputs updated this cycle
crc_error  output  1  one-cycle pulse; CRC mismatch, to master CRC_Error_Out
overrun_error  output  1  one-cycle pulse; byte_strobe arrived while CRC engine busy
byte_index  output  3  index of next expected byte, 0..5
busy  output  1  CRC engine shifting

Behaviour:
- Reset: all outputs 0; byte_index=0; CRC register=CRC_INIT; state RECV.
- Top FSM states:
  - RECV: accept bytes.
  - DISCARD: frame aborted; ignore byte_strobe until frame_start.
- CRC engine:
  - Sub-module, one bit per clk, MSB first.
  - load: shift count=8, busy=1 for exactly 8 cycles starting the cycle after the strobe.
  - Update rule: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
- Data bytes (index 0,1,3,4):
  - Latched into a holding word; byte fed to CRC engine; byte_index increments.
- CRC bytes (index 2,5):
  - Compared against the CRC register on the cycle after the strobe; engine is guaranteed idle (data bytes are ≥9 SCL periods apart).
  - Match at index 2: holding T word kept, CRC register reseeded to CRC_INIT, byte_index=3.
  - Match at index 5: temp_raw and rh_raw load together, frame_valid pulses, byte_index wraps to 0, CRC reseeded.
  - Mismatch: crc_error pulses 1 cycle after the strobe; go to DISCARD; temp_raw/rh_raw unchanged.
- Latency: frame_valid and crc_error occur 1 clk after the final or failing CRC byte strobe.
- Overrun: byte_strobe while busy=1 → overrun_error pulse, go to DISCARD, engine finishes and is ignored.
- frame_start:
  - From any state: byte_index=0, CRC=CRC_INIT, engine cancelled (busy=0), state RECV.
  - frame_start together with byte_strobe: frame_start wins, the byte is dropped.
- byte_strobe in DISCARD: no effect, no error pulses.
- Outputs never show a partially validated frame; temp_raw/rh_raw hold across errors.
- Async reset mid-frame: immediate return to reset values.

Optional Feature:
SHT40_CONVERT_EN:
- Defined: adds outputs temp_cdeg (signed 16, 0.01 °C) and rh_cpct (unsigned 16, 0.01 %RH), registered and updated in the same cycle as frame_valid.
  - temp_cdeg = -4500 + ((17500*temp_raw)>>16).
  - rh_cpct = clamp(-600 + ((12500*rh_raw)>>16), 0, 10000).
  - 32-bit intermediates.
- Undefined: ports and multipliers absent; raw outputs only.

Decomposition:
- Package sht40_pkg holds:
  - CRC_INIT, CRC_POLY, FRAME_BYTES.
  - Byte-index constants IDX_T_MSB..IDX_RH_CRC.
  - FSM state encoding RECV/DISCARD.
  - Conversion constants 17500, 4500, 12500, 600, 10000.
- Sub-module sht40_crc8_serial: load, data[7:0], seed, busy, crc[7:0]; reused by the command-write path later.

Test Plan:
- Good frame BE EF 92 00 00 81, strobes 40 clk apart → frame_valid 1 clk after 6th strobe, temp_raw=16'hBEEF, rh_raw=16'h0000, no errors.
- Bad T CRC BE EF 93 → crc_error 1 clk after 3rd strobe; bytes 4-6 ignored; temp_raw holds prior value; next frame_start plus the good frame → frame_valid.
- Overrun: byte 0 strobe, byte 1 strobe 3 clk later → overrun_error, DISCARD, no frame_valid for the remaining bytes.
- frame_start coincident with byte_strobe, then the good frame → first byte dropped, frame_valid after 6 subsequent strobes.
- rst asserted after byte 4 → outputs 0 immediately; a full good frame after release → frame_valid.
- SHT40_CONVERT_EN defined, good frame → temp_cdeg=8552, rh_cpct=0 (clamped) with frame_valid.
